fma16_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational fma16 datapath between two requesters. It accepts operations over per-requester valid/ready handshakes and registers the granted operation into a single issue stage that drives the datapath. It captures the datapath result into a one-entry response slot per requester and returns it over a valid/ready handshake. The block sits between the core's two FP issue sources and the fma16 unit.

---
 rtl/fma16_arbiter.sv | 132 +++++++++++++
 tb/tb_fma16_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_arbiter.sv
// Round-robin arbiter sharing one combinational fma16 datapath between two requesters.
// One issue register feeds the datapath; each requester owns a one-entry response slot.
module fma16_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid_0,
   input  logic        req_valid_1,
   output logic        req_ready_0,
   output logic        req_ready_1,
   input  logic [15:0] req_x_0,
   input  logic [15:0] req_y_0,
   input  logic [15:0] req_z_0,
   input  logic [15:0] req_x_1,
   input  logic [15:0] req_y_1,
   input  logic [15:0] req_z_1,
   input  logic [3:0]  req_op_0,
   input  logic [3:0]  req_op_1,
   input  logic [1:0]  req_rm_0,
   input  logic [1:0]  req_rm_1,
   output logic        rsp_valid_0,
   output logic        rsp_valid_1,
   input  logic        rsp_ready_0,
   input  logic        rsp_ready_1,
   output logic [15:0] rsp_result_0,
   output logic [15:0] rsp_result_1,
   output logic [3:0]  rsp_flags_0,
   output logic [3:0]  rsp_flags_1,
   output logic [15:0] fma_x,
   output logic [15:0] fma_y,
   output logic [15:0] fma_z,
   output logic        fma_mul,
   output logic        fma_add,
   output logic        fma_negp,
   output logic        fma_negz,
   output logic [1:0]  fma_roundmode,
   input  logic [15:0] fma_result,
   input  logic [3:0]  fma_flags,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUED, DONE} st_e;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [3:0]  op;
      logic [1:0]  rm;
   } op_t;

   op_t              req_s [2];
   op_t              iss_q;
   logic             iss_vld_q;
   logic             tag_q;
   logic             last_q, last_d;
   st_e              st_q [2];
   st_e              st_d [2];
   logic [1:0][15:0] res_q;
   logic [1:0][3:0]  flg_q;
   logic [1:0]       vld, rdy, elig, gnt;

   assign req_s[0] = '{x: req_x_0, y: req_y_0, z: req_z_0, op: req_op_0, rm: req_rm_0};
   assign req_s[1] = '{x: req_x_1, y: req_y_1, z: req_z_1, op: req_op_1, rm: req_rm_1};
   assign vld      = {req_valid_1, req_valid_0};
   assign rdy      = {rsp_ready_1, rsp_ready_0};

   // A DONE requester whose response pops this cycle may be regranted on the same edge.
   always_comb begin
      for (int i = 0; i < 2; i++)
         elig[i] = vld[i] & ((st_q[i] == IDLE) | ((st_q[i] == DONE) & rdy[i]));
      // Gating with reset_n keeps req_ready low while reset is asserted.
      gnt[0] = reset_n & elig[0] & (~elig[1] | last_q);
      gnt[1] = reset_n & elig[1] & (~elig[0] | ~last_q);
      last_d = last_q;
      if (|gnt) last_d = gnt[1];
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i] = st_q[i];
         if (gnt[i])
            st_d[i] = ISSUED;
         else if (iss_vld_q && (tag_q == i[0]))
            st_d[i] = DONE;
         else if ((st_q[i] == DONE) && rdy[i])
            st_d[i] = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) st_q[i] <= IDLE;
         last_q    <= 1'b1;
         iss_vld_q <= 1'b0;
         tag_q     <= 1'b0;
         iss_q     <= '0;
         res_q     <= '0;
         flg_q     <= '0;
      end else begin
         for (int i = 0; i < 2; i++) st_q[i] <= st_d[i];
         last_q    <= last_d;
         iss_vld_q <= |gnt;
         if (|gnt) begin
            iss_q <= gnt[1] ? req_s[1] : req_s[0];
            tag_q <= gnt[1];
         end
         if (iss_vld_q) begin
            res_q[tag_q] <= fma_result;
            flg_q[tag_q] <= fma_flags;
         end
      end
   end

   assign req_ready_0   = gnt[0];
   assign req_ready_1   = gnt[1];
   assign rsp_valid_0   = (st_q[0] == DONE);
   assign rsp_valid_1   = (st_q[1] == DONE);
   assign rsp_result_0  = res_q[0];
   assign rsp_result_1  = res_q[1];
   assign rsp_flags_0   = flg_q[0];
   assign rsp_flags_1   = flg_q[1];
   assign fma_x         = iss_q.x;
   assign fma_y         = iss_q.y;
   assign fma_z         = iss_q.z;
   assign fma_mul       = iss_q.op[3];
   assign fma_add       = iss_q.op[2];
   assign fma_negp      = iss_q.op[1];
   assign fma_negz      = iss_q.op[0];
   assign fma_roundmode = iss_q.rm;
   assign busy          = iss_vld_q | rsp_valid_0 | rsp_valid_1;

endmodule

// File: tb/tb_fma16_arbiter.sv
// Scoreboard bench for fma16_arbiter with a stand-in datapath function.
module tb_fma16_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid_0 = 0, req_valid_1 = 0;
   logic        req_ready_0, req_ready_1;
   logic [15:0] req_x_0 = 0, req_y_0 = 0, req_z_0 = 0;
   logic [15:0] req_x_1 = 0, req_y_1 = 0, req_z_1 = 0;
   logic [3:0]  req_op_0 = 0, req_op_1 = 0;
   logic [1:0]  req_rm_0 = 0, req_rm_1 = 0;
   logic        rsp_valid_0, rsp_valid_1;
   logic        rsp_ready_0 = 0, rsp_ready_1 = 0;
   logic [15:0] rsp_result_0, rsp_result_1;
   logic [3:0]  rsp_flags_0, rsp_flags_1;
   logic [15:0] fma_x, fma_y, fma_z;
   logic        fma_mul, fma_add, fma_negp, fma_negz;
   logic [1:0]  fma_roundmode;
   logic [15:0] fma_result;
   logic [3:0]  fma_flags;
   logic        busy;

   always #5 clk = ~clk;

   fma16_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_x_0(req_x_0), .req_y_0(req_y_0), .req_z_0(req_z_0),
      .req_x_1(req_x_1), .req_y_1(req_y_1), .req_z_1(req_z_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .req_rm_0(req_rm_0), .req_rm_1(req_rm_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
      .rsp_flags_0(rsp_flags_0), .rsp_flags_1(rsp_flags_1),
      .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
      .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
      .fma_roundmode(fma_roundmode),
      .fma_result(fma_result), .fma_flags(fma_flags),
      .busy(busy)
   );

   // Stand-in datapath: real fp16 answers for the directed vectors, an asymmetric mix otherwise.
   function automatic logic [19:0] fake(input logic [15:0] x, y, z, input logic [3:0] op,
                                        input logic [1:0] rm);
      logic [15:0] r;
      if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && op == 4'b1100 && rm == 2'd0)
         return {16'h4200, 4'b0000};
      if (x == 16'h7C00 && y == 16'h0000 && op == 4'b1000)
         return {16'h7E00, 4'b1000};
      r = (x ^ {y[7:0], y[15:8]}) + z + {op, rm, 10'd0};
      return {r, op ^ {2'b00, rm}};
   endfunction

   assign {fma_result, fma_flags} = fake(fma_x, fma_y, fma_z,
                                         {fma_mul, fma_add, fma_negp, fma_negz}, fma_roundmode);

   int          n_chk = 0, n_pass = 0, out_cnt = 0;
   logic [19:0] q0[$], q1[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         out_cnt = 0;
      end else begin
         chk("one_grant", 32'(req_ready_0 & req_ready_1), 0);
         chk("busy", 32'(busy), 32'(out_cnt != 0));
         if (rsp_valid_0) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
            else begin
               chk("rsp0", 32'({rsp_result_0, rsp_flags_0}), 32'(q0[0]));
               if (rsp_ready_0) begin void'(q0.pop_front()); out_cnt--; end
            end
         end
         if (rsp_valid_1) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else begin
               chk("rsp1", 32'({rsp_result_1, rsp_flags_1}), 32'(q1[0]));
               if (rsp_ready_1) begin void'(q1.pop_front()); out_cnt--; end
            end
         end
         if (req_ready_0) begin
            chk("rdy0_needs_valid", 32'(req_valid_0), 1);
            q0.push_back(fake(req_x_0, req_y_0, req_z_0, req_op_0, req_rm_0));
            out_cnt++;
         end
         if (req_ready_1) begin
            chk("rdy1_needs_valid", 32'(req_valid_1), 1);
            q1.push_back(fake(req_x_1, req_y_1, req_z_1, req_op_1, req_rm_1));
            out_cnt++;
         end
      end
   end

   task automatic nx(); @(posedge clk); #1; endtask
   task automatic ng(); @(negedge clk); endtask

   task automatic drv(input int i, input logic v, input logic [15:0] x, y, z,
                      input logic [3:0] op, input logic [1:0] rm);
      if (i == 0) begin
         req_valid_0 = v; req_x_0 = x; req_y_0 = y; req_z_0 = z; req_op_0 = op; req_rm_0 = rm;
      end else begin
         req_valid_1 = v; req_x_1 = x; req_y_1 = y; req_z_1 = z; req_op_1 = op; req_rm_1 = rm;
      end
   endtask

   task automatic drain(input int n);
      drv(0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0);
      rsp_ready_0 = 1; rsp_ready_1 = 1;
      repeat (n) nx();
   endtask

   int cnt;

   initial begin
      repeat (2) nx();
      reset_n = 1;
      ng();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rv", 32'({rsp_valid_1, rsp_valid_0}), 0);
      chk("rst_rdy", 32'({req_ready_1, req_ready_0}), 0);
      chk("rst_fma", 32'({fma_x, fma_mul, fma_add, fma_roundmode}), 0);
      chk("rst_res", 32'({rsp_result_0, rsp_flags_1}), 0);

      // single op on requester 0
      nx(); drv(0, 1, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'd0);
      ng(); chk("t1_rdy0", 32'(req_ready_0), 1); chk("t1_rdy1", 32'(req_ready_1), 0);
      nx(); drv(0, 0, 0, 0, 0, 0, 0);
      ng(); chk("t1_early", 32'(rsp_valid_0), 0); chk("t1_fma_x", 32'(fma_x), 32'h3C00);
      chk("t1_fma_op", 32'({fma_mul, fma_add, fma_negp, fma_negz}), 32'hC);
      nx();
      ng(); chk("t1_v0", 32'(rsp_valid_0), 1); chk("t1_res", 32'(rsp_result_0), 32'h4200);
      chk("t1_flags", 32'(rsp_flags_0), 0); chk("t1_v1", 32'(rsp_valid_1), 0);
      nx(); rsp_ready_0 = 1;
      nx(); rsp_ready_0 = 0;
      ng(); chk("t1_popped", 32'(rsp_valid_0), 0);

      // reset, then tie and alternation
      nx(); reset_n = 0;
      nx(); reset_n = 1; rsp_ready_0 = 1; rsp_ready_1 = 1;
      for (int k = 0; k < 20; k++) begin
         drv(0, 1, 16'(k * 3 + 1), 16'h1234, 16'(k), 4'b1100, 2'(k));
         drv(1, 1, 16'(k * 5 + 7), 16'h0F0F, 16'(k * 2), 4'b0110, 2'(k + 1));
         ng();
         chk("tie_r0", 32'(req_ready_0), 32'(k % 2 == 0));
         chk("tie_r1", 32'(req_ready_1), 32'(k % 2 == 1));
         nx();
      end
      drain(5);

      // backpressure on requester 0 while requester 1 streams
      rsp_ready_0 = 0; rsp_ready_1 = 1;
      drv(0, 1, 16'h1111, 16'h2222, 16'h3333, 4'b1100, 2'd1);
      ng(); chk("bp_acc0", 32'(req_ready_0), 1);
      nx(); drv(0, 1, 16'h4444, 16'h5555, 16'h6666, 4'b1010, 2'd2);
      drv(1, 1, 16'hABCD, 16'h0102, 16'h0304, 4'b1100, 2'd3);
      nx();
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         ng();
         chk("bp_hold", 32'({rsp_valid_0, rsp_result_0}),
             32'({1'b1, fake(16'h1111, 16'h2222, 16'h3333, 4'b1100, 2'd1)} >> 4));
         chk("bp_rdy0", 32'(req_ready_0), 0);
         cnt += int'(req_ready_1);
         nx();
      end
      chk("bp_r1_rate", 32'(cnt), 2);
      rsp_ready_0 = 1;
      ng(); chk("bp_bypass", 32'(req_ready_0), 1);
      nx(); drain(6);

      // flags to requester 1, then hold slot 1 for the reset test
      rsp_ready_0 = 0; rsp_ready_1 = 0;
      drv(1, 1, 16'h7C00, 16'h0000, 16'h1234, 4'b1000, 2'd0);
      ng(); chk("fl_rdy1", 32'(req_ready_1), 1);
      nx(); drv(1, 0, 0, 0, 0, 0, 0);
      nx();
      ng(); chk("fl_v", 32'({rsp_valid_1, rsp_valid_0}), 32'b10);
      chk("fl_res", 32'({rsp_result_1, rsp_flags_1}), 32'h7E008);

      // async reset with an op in flight and slot 1 full
      nx(); drv(0, 1, 16'h0101, 16'h0202, 16'h0303, 4'b1101, 2'd2);
      ng(); chk("ar_acc0", 32'(req_ready_0), 1);
      nx(); #1 reset_n = 0; #1;
      chk("ar_rv", 32'({rsp_valid_1, rsp_valid_0}), 0);
      chk("ar_rdy", 32'({req_ready_1, req_ready_0}), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_fma", 32'({fma_x ^ fma_y ^ fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode}), 0);
      chk("ar_res1", 32'({rsp_result_1, rsp_flags_1}), 0);
      ng();
      nx(); reset_n = 1;
      drv(1, 1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 4'b0100, 2'd1);
      ng(); chk("ar_stale", 32'({rsp_valid_1, rsp_valid_0}), 0);
      chk("ar_tie", 32'({req_ready_1, req_ready_0}), 32'b01);
      nx(); drain(6);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         drv(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 2'($urandom));
         drv(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 2'($urandom));
         rsp_ready_0 = ($urandom_range(0, 9) < 7);
         rsp_ready_1 = ($urandom_range(0, 9) < 6);
         nx();
      end
      drain(10);
      ng();
      chk("end_q0_empty", 32'(q0.size()), 0);
      chk("end_q1_empty", 32'(q1.size()), 0);
      chk("end_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
